// File: rtl/cover_toggle_drain.sv
// cover_toggle_drain
// Deduplicating toggle-coverage collector. The first hit on each point is
// latched into a pending bitmap, and pending points are streamed out one
// global index per cycle over a valid/ready channel in round-robin order.
// A clear pulse drains any in-flight beat, then re-arms every point.
module cover_toggle_drain #(
  parameter int WIDTH       = 120,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 28338,
  parameter int CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  valid,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_index,
  output logic [CNT_W-1:0]  pending_count,
  output logic [CNT_W-1:0]  covered_count,
  output logic              busy
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Number of set bits in a point bitmap.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      cnt = cnt + CNT_W'(v[k]);
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; returns 0 when the vector is empty, so
  // callers must qualify the result with a non-empty test.
  function automatic logic [PTR_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (v[k]) idx = PTR_W'(k);
    end
    return idx;
  endfunction

  // Mask selecting every bit position at or above the round-robin pointer.
  function automatic logic [WIDTH-1:0] at_or_above(input logic [PTR_W-1:0] p);
    logic [WIDTH-1:0] m;
    for (int k = 0; k < WIDTH; k++) begin
      m[k] = (k >= int'(p));
    end
    return m;
  endfunction

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   seen_q,      seen_d;
  logic [WIDTH-1:0]   pending_q,   pending_d;
  logic [PTR_W-1:0]   ptr_q,       ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_index_q, out_index_d;

  logic [WIDTH-1:0]   new_hits;
  logic [WIDTH-1:0]   upper_pending;
  logic [PTR_W-1:0]   sel_idx;
  logic               capture;
  logic               load;
  logic               accept;
  logic               any_pending;

  // Selection, capture qualification and handshake decode.
  always_comb begin
    any_pending   = |pending_q;
    new_hits      = valid & ~seen_q;
    // Hits in a clear cycle are dropped: they would otherwise be wiped by
    // the flush anyway, but would briefly inflate the counts.
    capture       = enable && (state_q != ST_FLUSH) && !clear;
    upper_pending = pending_q & at_or_above(ptr_q);
    // Round-robin: first pending point at/after ptr, else wrap to lowest.
    sel_idx       = (|upper_pending) ? lowest_set(upper_pending)
                                     : lowest_set(pending_q);
    load          = (!out_valid_q || out_ready) && (state_q != ST_FLUSH)
                    && any_pending;
    accept        = out_valid_q && out_ready;
  end

  // Next-state computation for bitmaps, pointer, output beat and FSM.
  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;

    if (state_q == ST_FLUSH) begin
      // Let any outstanding beat finish, then re-arm everything at once.
      if (accept) begin
        out_valid_d = 1'b0;
      end
      if (!out_valid_q || out_ready) begin
        seen_d    = '0;
        pending_d = '0;
        ptr_d     = '0;
        state_d   = ST_IDLE;
      end
    end else begin
      if (load) begin
        out_valid_d        = 1'b1;
        out_index_d        = 64'(COVER_INDEX) + 64'(sel_idx);
        pending_d[sel_idx] = 1'b0;
        ptr_d              = (sel_idx == PTR_W'(WIDTH - 1)) ? '0
                                                            : sel_idx + PTR_W'(1);
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end

      // The selected bit is already in seen, so it cannot be re-pended here.
      if (capture) begin
        seen_d    = seen_q | new_hits;
        pending_d = pending_d | new_hits;
      end

      if (clear) begin
        state_d = ST_FLUSH;
      end else if ((state_q == ST_IDLE) && any_pending) begin
        state_d = ST_DRAIN;
      end else if ((state_q == ST_DRAIN) && !any_pending && !load) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; the asynchronous reset also discards any un-accepted beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      seen_q      <= '0;
      pending_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

  // Outputs are either registers or popcounts of registered bitmaps.
  always_comb begin
    out_valid     = out_valid_q;
    out_index     = out_index_q;
    pending_count = popcount(pending_q);
    covered_count = popcount(seen_q);
    busy          = (state_q != ST_IDLE) || out_valid_q;
  end

endmodule
